// File: rtl/ds_link_pkg.sv
// Shared encodings for the DS link transmit scheduler: character types,
// link start-up states and the credit granted per received FCT.
package ds_link_pkg;

    localparam logic [1:0] CH_NULL = 2'b00;
    localparam logic [1:0] CH_FCT  = 2'b01;
    localparam logic [1:0] CH_DATA = 2'b10;
    localparam logic [1:0] CH_EOP  = 2'b11;

    localparam int FCT_CREDIT = 8;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_CONNECT = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // One bit of headroom so a +8 that crosses the ceiling is still visible.
    function automatic logic [6:0] credit_next(input logic [5:0] cur,
                                               input logic       add,
                                               input logic       sub);
        return {1'b0, cur} + (add ? 7'(FCT_CREDIT) : 7'd0) - (sub ? 7'd1 : 7'd0);
    endfunction

endpackage

// File: rtl/ds_link_scheduler_if.sv
// Character hand-off between the scheduler (master) and the DS encoder (slave).
interface ds_link_scheduler_if;

    // A character transfers on a cycle where ch_valid && ch_ready; once valid
    // is raised, ch_type/ch_data hold stable until that transfer happens.
    logic       ch_valid;
    logic       ch_ready;
    logic [1:0] ch_type;
    logic [7:0] ch_data;

    modport master (output ch_valid, ch_type, ch_data, input ch_ready);
    modport slave  (input ch_valid, ch_type, ch_data, output ch_ready);

endinterface

// File: rtl/ds_rr_arbiter.sv
// Requester arbiter: round-robin with DS_SCHED_RR_EN defined, otherwise a
// fixed lowest-index-wins priority encoder with no pointer register.
module ds_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         upd_en_i,
    output logic [N-1:0] grant_o
);

    logic found;

`ifdef DS_SCHED_RR_EN
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    int            idx;

    // Search starts one above the last winner, wrapping at N.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + 1 + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx[PW-1:0]]) begin
                grant_o[idx[PW-1:0]] = 1'b1;
                ptr_d                = idx[PW-1:0];
                found                = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else if (upd_en_i) begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, upd_en_i};

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ds_link_scheduler.sv
// Transmit-side character scheduler for a DS link: start-up sequencing,
// credit flow control and requester arbitration. Arbitration style: DS_SCHED_RR_EN.
module ds_link_scheduler
    import ds_link_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_CREDIT = 56
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_eop,
    output logic [NUM_REQ-1:0]   req_grant,
    input  logic                 fct_req,
    input  logic                 fct_rcvd,
    input  logic                 null_rcvd,
    input  logic                 link_err,
    ds_link_scheduler_if.master  ch,
    output logic [5:0]           credit,
    output logic                 link_run,
    output logic                 credit_err,
    output state_t               state_dbg
);

    state_t       state_q, state_d;
    logic [2:0]   pend_q, pend_d;
    logic [5:0]   credit_q, credit_d;
    logic         cerr_q, cerr_d;
    logic         chv_q, chv_d;
    logic [1:0]   cht_q, cht_d;
    logic [7:0]   chd_q, chd_d;

    logic         load, fct_sel, data_sel, take_fct, take_data;
    logic [NUM_REQ-1:0] arb_grant;
    logic [7:0]   sel_data;
    logic         sel_eop;
    logic [6:0]   credit_sum;

    ds_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .upd_en_i (take_data),
        .grant_o  (arb_grant)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        credit_d = credit_q;
        cerr_d   = cerr_q;
        chv_d    = chv_q;
        cht_d    = cht_q;
        chd_d    = chd_q;

        load      = !chv_q || ch.ch_ready;
        fct_sel   = (pend_q != 3'd0) && (state_q != ST_INIT);
        data_sel  = !fct_sel && (state_q == ST_RUN) && (credit_q != 6'd0) && (|req_valid);
        take_fct  = load && fct_sel && !link_err;
        take_data = load && data_sel && !link_err;

        sel_data = 8'h00;
        sel_eop  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = req_data[8*i +: 8];
                sel_eop  = req_eop[i];
            end
        end

        // FCTs arriving before the far end has sent NULLs are not credited.
        credit_sum = credit_next(credit_q, fct_rcvd && (state_q != ST_INIT), take_data);

        if (link_err) begin
            state_d  = ST_INIT;
            pend_d   = 3'd0;
            credit_d = 6'd0;
            cerr_d   = 1'b0;
            chv_d    = 1'b0;
            cht_d    = CH_NULL;
            chd_d    = 8'h00;
        end else begin
            case (state_q)
                ST_INIT:    if (null_rcvd) state_d = ST_CONNECT;
                ST_CONNECT: if (fct_rcvd)  state_d = ST_RUN;
                ST_RUN:     state_d = ST_RUN;
                default:    state_d = ST_INIT;
            endcase

            if (fct_req && !take_fct) begin
                if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
            end else if (!fct_req && take_fct) begin
                pend_d = pend_q - 3'd1;
            end

            if (credit_sum > 7'(MAX_CREDIT)) begin
                credit_d = 6'(MAX_CREDIT);
                cerr_d   = 1'b1;
            end else begin
                credit_d = credit_sum[5:0];
            end

            if (load) begin
                chv_d = 1'b1;
                if (take_fct) begin
                    cht_d = CH_FCT;
                    chd_d = 8'h00;
                end else if (take_data) begin
                    cht_d = sel_eop ? CH_EOP : CH_DATA;
                    chd_d = sel_eop ? 8'h00 : sel_data;
                end else begin
                    cht_d = CH_NULL;
                    chd_d = 8'h00;
                end
            end
        end

        req_grant = take_data ? arb_grant : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            pend_q   <= 3'd0;
            credit_q <= 6'd0;
            cerr_q   <= 1'b0;
            chv_q    <= 1'b0;
            cht_q    <= CH_NULL;
            chd_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            credit_q <= credit_d;
            cerr_q   <= cerr_d;
            chv_q    <= chv_d;
            cht_q    <= cht_d;
            chd_q    <= chd_d;
        end
    end

    assign ch.ch_valid = chv_q;
    assign ch.ch_type  = cht_q;
    assign ch.ch_data  = chd_q;
    assign credit      = credit_q;
    assign link_run    = (state_q == ST_RUN);
    assign credit_err  = cerr_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/ds_link_scheduler.md
# ds_link_scheduler

Transmit-side character scheduler for the IEEE 1355 data-strobe link node. It shares the single DS encoder between NUM_REQ local data requesters and the link's own flow-control traffic. It sequences link start-up (NULL → FCT → data), enforces credit-based flow control, and hands one character at a time to the encoder over a valid/ready handshake.

## Interface
- NUM_REQ, 4: number of data requesters (2..8)
- MAX_CREDIT, 56: credit ceiling; must be a multiple of 8
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a character
- req_data  in  8*NUM_REQ  flattened data bytes; requester i at [8i+7:8i]
- req_eop  in  NUM_REQ  character of requester i is an end-of-packet marker; its req_data is ignored
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse: requester i's character was latched
- fct_req  in  1  pulse: the local receiver has freed 8 buffer slots
- fct_rcvd  in  1  pulse: an FCT was decoded from the far end
- null_rcvd  in  1  pulse: a NULL was decoded from the far end
- link_err  in  1  pulse: disconnect, parity or escape error from the decoder
- ch_valid  out  1  output character valid
- ch_ready  in  1  encoder accepts the character
- ch_type  out  2  00 NULL, 01 FCT, 10 DATA, 11 EOP
- ch_data  out  8  data byte; 0 unless ch_type is DATA
- credit  out  6  current transmit credit
- link_run  out  1  high in state RUN
- credit_err  out  1  sticky credit-overflow flag; cleared by rst or link_err

## Operation
- States:
  - INIT: send NULLs only. Move to CONNECT on null_rcvd.
  - CONNECT: send NULLs and pending FCTs, no data. Move to RUN on the first fct_rcvd.
  - RUN: send everything.
- link_err in any state has priority: go to INIT, clear credit, clear pending-FCT count, flush the output register (ch_valid=0 next cycle).
- Output register load condition: !ch_valid || ch_ready.
- Selection on each load, in priority order:
  1. FCT, if pending_fct>0 and state≠INIT.
  2. DATA/EOP, if state=RUN, credit>0 and any req_valid.
  3. NULL.
- pending_fct: 3-bit counter.
  - +1 on fct_req, saturating at 7.
  - −1 when an FCT is latched.
  - Simultaneous +1 and −1 leaves it unchanged.
- credit:
  - +8 on fct_rcvd.
  - −1 when a DATA/EOP is latched.
  - Simultaneous events give a net +7.
  - If the result would exceed MAX_CREDIT, it saturates at MAX_CREDIT and credit_err is set.
  - The first fct_rcvd in CONNECT also credits 8.
- Requester arbitration is round-robin. The search starts one index above the last granted requester. req_grant[i] pulses in the same cycle the character is latched. The requester must present its next character (or drop req_valid) on the following cycle.
- While ch_valid && !ch_ready, ch_type and ch_data hold stable and no grant is issued.

## Timing
- All outputs are 0 in reset. The pointer resets to NUM_REQ−1, so requester 0 wins first.
- The first cycle after rst deasserts latches a NULL (ch_valid=1).
- Latency from request to output: 1 cycle. A char selected in cycle N is presented on ch_valid/ch_type in N+1.
- Throughput: 1 char per cycle while ch_ready is held high.
- State changes take effect for the selection made in the following cycle. credit and link_run are registered.
- Reset mid-character: the character is dropped and no grant is issued.

## Configuration
- DS_SCHED_RR_EN defined: round-robin arbitration as above.
- DS_SCHED_RR_EN undefined: fixed priority, lowest requester index wins. The pointer register is not synthesised. All other behaviour is identical.

## Structure
- Shared package ds_link_pkg holds:
  - char type localparams CH_NULL/CH_FCT/CH_DATA/CH_EOP
  - state encodings ST_INIT/ST_CONNECT/ST_RUN
  - FCT_CREDIT=8
- Sub-module ds_rr_arbiter: NUM_REQ-wide round-robin grant with a pointer update enable. It is replaced by a priority encoder when DS_SCHED_RR_EN is undefined.

## Test plan
- Reset, then ch_ready=1 with no far-end traffic: a continuous NULL stream, link_run=0, credit=0, req_valid=4'b1111 never granted.
- null_rcvd, fct_req×2, fct_rcvd: two FCTs sent in CONNECT, then RUN with credit=8.
- RUN, credit=8, all four requesters valid continuously: grants rotate 0,1,2,3,0,1,2,3. After 8 chars credit=0 and only NULLs follow until the next fct_rcvd.
- fct_rcvd in the same cycle as a DATA latch with credit=5: credit becomes 12. Seven further fct_rcvd pulses: credit=56 and credit_err=1.
- ch_ready=0 for 5 cycles with a DATA char 0xA5 pending: output held at 10/0xA5, no req_grant, credit unchanged.
- link_err during RUN with credit=24 and pending_fct=3: next cycle state INIT, credit=0, ch_valid=0, then NULLs only, no FCT sent.
